// File: rtl/rtc_edit_ctrl.sv
// rtc_edit_ctrl: button-driven editor for the RTC time / date / timer groups.
// Walks the user through the three groups (hora -> fecha -> timer), steers the
// field address and group enables of the decoder, strobes the field counters,
// and commits each group to the RTC writer through a req/ack handshake.
// Optional build macro: EDIT_TIMEOUT_EN adds an inactivity timeout that
// abandons the edit (no commit) and pulses abort.
module rtc_edit_ctrl #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000,
    parameter int          TO_W           = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_mode,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       wr_ack,
    output logic [1:0] dir_bin,
    output logic       en_cont_hora,
    output logic       en_cont_fecha,
    output logic       en_cont_timer,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       wr_req,
    output logic [1:0] wr_grp,
    output logic       edit_active,
    output logic       abort
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EDIT   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t     r_state;
    logic [1:0] r_grp;
    logic [1:0] r_dir;
    logic [2:0] r_en;        // {timer, fecha, hora}
    logic       r_inc;
    logic       r_dec;
    logic       r_wr_req;
    logic [1:0] r_wr_grp;
    logic       r_edit_active;
    logic       r_abort;

    logic       w_timeout;
    logic       w_move;
    logic       w_right;
    logic       w_left;

    // One-hot group enable; group code 3 never enables anything.
    function automatic logic [2:0] f_grp_en(input logic [1:0] g);
        logic [2:0] e;
        e = 3'b000;
        case (g)
            2'd0:    e = 3'b001;
            2'd1:    e = 3'b010;
            2'd2:    e = 3'b100;
            default: e = 3'b000;
        endcase
        return e;
    endfunction

    // Any left/right activity claims the cycle, even when both cancel out.
    assign w_move  = btn_left | btn_right;
    assign w_right = btn_right & ~btn_left;
    assign w_left  = btn_left & ~btn_right;

`ifdef EDIT_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 32'd1);

    logic [TO_W-1:0] r_to_cnt;
    logic            w_any_btn;

    assign w_any_btn = btn_mode | btn_left | btn_right | btn_up | btn_down;

    // Inactivity counter: cleared by any press or by re-entering EDIT after a
    // commit; advances only while editing, holds elsewhere.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt <= '0;
        end else if (w_any_btn || (r_state == S_COMMIT && wr_ack)) begin
            r_to_cnt <= '0;
        end else if (r_state == S_EDIT) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // A press in the terminal cycle beats the timeout.
    assign w_timeout = (r_state == S_EDIT) && !w_any_btn && (r_to_cnt == TO_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    // Edit sequencer: state, group/field selection and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_grp         <= 2'd0;
            r_dir         <= 2'd0;
            r_en          <= 3'b000;
            r_inc         <= 1'b0;
            r_dec         <= 1'b0;
            r_wr_req      <= 1'b0;
            r_wr_grp      <= 2'd0;
            r_edit_active <= 1'b0;
            r_abort       <= 1'b0;
        end else begin
            r_inc   <= 1'b0;
            r_dec   <= 1'b0;
            r_abort <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_en          <= 3'b000;
                    r_wr_req      <= 1'b0;
                    r_edit_active <= 1'b0;
                    r_dir         <= 2'd0;
                    if (btn_mode) begin
                        r_state       <= S_EDIT;
                        r_grp         <= 2'd0;
                        r_en          <= f_grp_en(2'd0);
                        r_edit_active <= 1'b1;
                    end
                end

                S_EDIT: begin
                    if (r_grp == 2'd3) begin
                        // Corrupt group: fall back to a clean idle.
                        r_state       <= S_IDLE;
                        r_grp         <= 2'd0;
                        r_dir         <= 2'd0;
                        r_en          <= 3'b000;
                        r_edit_active <= 1'b0;
                    end else if (btn_mode) begin
                        r_state  <= S_COMMIT;
                        r_wr_req <= 1'b1;
                        r_wr_grp <= r_grp;
                        r_en     <= 3'b000;
                    end else if (w_timeout) begin
                        // Abandon the edit; nothing is committed.
                        r_state       <= S_IDLE;
                        r_grp         <= 2'd0;
                        r_dir         <= 2'd0;
                        r_en          <= 3'b000;
                        r_edit_active <= 1'b0;
                        r_abort       <= 1'b1;
                    end else if (w_move) begin
                        if (w_right) begin
                            r_dir <= (r_dir == 2'd2) ? 2'd0 : r_dir + 2'd1;
                        end else if (w_left) begin
                            r_dir <= (r_dir == 2'd0) ? 2'd2 : r_dir - 2'd1;
                        end
                    end else begin
                        r_inc <= btn_up & ~btn_down;
                        r_dec <= btn_down & ~btn_up;
                    end
                end

                S_COMMIT: begin
                    if (r_grp == 2'd3) begin
                        r_state       <= S_IDLE;
                        r_grp         <= 2'd0;
                        r_dir         <= 2'd0;
                        r_en          <= 3'b000;
                        r_wr_req      <= 1'b0;
                        r_edit_active <= 1'b0;
                    end else if (wr_ack) begin
                        r_wr_req <= 1'b0;
                        r_dir    <= 2'd0;
                        if (r_grp == 2'd2) begin
                            r_state       <= S_IDLE;
                            r_grp         <= 2'd0;
                            r_en          <= 3'b000;
                            r_edit_active <= 1'b0;
                        end else begin
                            r_state <= S_EDIT;
                            r_grp   <= r_grp + 2'd1;
                            r_en    <= f_grp_en(r_grp + 2'd1);
                        end
                    end
                end

                default: begin
                    r_state       <= S_IDLE;
                    r_grp         <= 2'd0;
                    r_dir         <= 2'd0;
                    r_en          <= 3'b000;
                    r_wr_req      <= 1'b0;
                    r_edit_active <= 1'b0;
                end
            endcase
        end
    end

    assign dir_bin       = r_dir;
    assign en_cont_hora  = r_en[0];
    assign en_cont_fecha = r_en[1];
    assign en_cont_timer = r_en[2];
    assign inc_pulse     = r_inc;
    assign dec_pulse     = r_dec;
    assign wr_req        = r_wr_req;
    assign wr_grp        = r_wr_grp;
    assign edit_active   = r_edit_active;
    assign abort         = r_abort;

endmodule

// File: tb/tb_rtc_edit_ctrl.sv
// Bench for rtc_edit_ctrl: directed button sequences, a behavioural model of
// the editing rules checked on every cycle, and literal spot checks.
module tb_rtc_edit_ctrl;

`ifdef EDIT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int TO_CYC = 16;

    // press masks: {ack, down, up, right, left, mode}
    localparam logic [5:0] B_MODE  = 6'b000001;
    localparam logic [5:0] B_LEFT  = 6'b000010;
    localparam logic [5:0] B_RIGHT = 6'b000100;
    localparam logic [5:0] B_UP    = 6'b001000;
    localparam logic [5:0] B_DOWN  = 6'b010000;
    localparam logic [5:0] B_ACK   = 6'b100000;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       btn_mode, btn_left, btn_right, btn_up, btn_down, wr_ack;
    logic [1:0] dir_bin;
    logic       en_cont_hora, en_cont_fecha, en_cont_timer;
    logic       inc_pulse, dec_pulse, wr_req;
    logic [1:0] wr_grp;
    logic       edit_active, abort;

    int n_cmp = 0;
    int n_err = 0;

    rtc_edit_ctrl #(.TIMEOUT_CYCLES(32'd16), .TO_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .btn_mode(btn_mode), .btn_left(btn_left), .btn_right(btn_right),
        .btn_up(btn_up), .btn_down(btn_down), .wr_ack(wr_ack),
        .dir_bin(dir_bin), .en_cont_hora(en_cont_hora),
        .en_cont_fecha(en_cont_fecha), .en_cont_timer(en_cont_timer),
        .inc_pulse(inc_pulse), .dec_pulse(dec_pulse),
        .wr_req(wr_req), .wr_grp(wr_grp),
        .edit_active(edit_active), .abort(abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 editing, 2 committing; fld is the selected field 0..2;
    // quiet counts editing cycles since the last press.
    int m_mode = 0, m_grp = 0, m_fld = 0, m_wgrp = 0, m_quiet = 0;
    bit m_inc = 0, m_dec = 0, m_req = 0, m_abort = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode = 0; m_grp = 0; m_fld = 0; m_wgrp = 0; m_quiet = 0;
            m_inc = 0; m_dec = 0; m_req = 0; m_abort = 0;
        end else begin
            bit any;
            any = btn_mode | btn_left | btn_right | btn_up | btn_down;
            m_inc = 0; m_dec = 0; m_abort = 0;
            if (m_mode == 0) begin
                if (btn_mode) begin m_mode = 1; m_grp = 0; m_fld = 0; m_quiet = 0; end
            end else if (m_mode == 1) begin
                if (btn_mode) begin
                    m_mode = 2; m_req = 1; m_wgrp = m_grp;
                end else if (TO_EN && !any && m_quiet == TO_CYC - 1) begin
                    m_mode = 0; m_abort = 1; m_fld = 0; m_grp = 0;
                end else begin
                    m_quiet = any ? 0 : m_quiet + 1;
                    if (btn_right && !btn_left)      m_fld = (m_fld + 1) % 3;
                    else if (btn_left && !btn_right) m_fld = (m_fld + 2) % 3;
                    else if (!btn_left && !btn_right) begin
                        m_inc = btn_up && !btn_down;
                        m_dec = btn_down && !btn_up;
                    end
                end
            end else begin
                if (wr_ack) begin
                    m_req = 0; m_fld = 0;
                    if (m_grp == 2) m_mode = 0;
                    else begin m_grp = m_grp + 1; m_mode = 1; m_quiet = 0; end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        @(negedge reset_n);
        forever begin
            @(negedge clk);
            chk("dir_bin", 32'(dir_bin), 32'(m_fld));
            chk("en_hora", 32'(en_cont_hora), 32'(m_mode == 1 && m_grp == 0));
            chk("en_fecha", 32'(en_cont_fecha), 32'(m_mode == 1 && m_grp == 1));
            chk("en_timer", 32'(en_cont_timer), 32'(m_mode == 1 && m_grp == 2));
            chk("inc", 32'(inc_pulse), 32'(m_inc));
            chk("dec", 32'(dec_pulse), 32'(m_dec));
            chk("wr_req", 32'(wr_req), 32'(m_req));
            if (m_req) chk("wr_grp", 32'(wr_grp), 32'(m_wgrp));
            chk("edit_active", 32'(edit_active), 32'(m_mode != 0));
            chk("abort", 32'(abort), 32'(m_abort));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [5:0] m);
        {wr_ack, btn_down, btn_up, btn_right, btn_left, btn_mode} = m;
    endtask

    // One-cycle pulse; returns just after the edge that registered it.
    task automatic press(input logic [5:0] m);
        @(posedge clk); #1 drive(m);
        @(posedge clk); #1 drive(6'd0);
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        @(posedge clk); #2 reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
    endtask

    initial begin
        int hit;
        drive(6'd0);
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        step(2);
        chk("rst_dir", 32'(dir_bin), 0);
        chk("rst_en", 32'({en_cont_timer, en_cont_fecha, en_cont_hora}), 0);
        chk("rst_wr_req", 32'(wr_req), 0);
        chk("rst_active", 32'(edit_active), 0);
        @(negedge clk) reset_n = 1'b1;

        // idle ignores edit buttons and stray acks
        press(B_UP);   chk("idle_inc", 32'(inc_pulse), 0);
        press(B_ACK);  chk("idle_ack", 32'(wr_req), 0);

        // hora: field walk
        press(B_MODE);  chk("hora_en", 32'(en_cont_hora), 1); chk("hora_dir", 32'(dir_bin), 0);
        press(B_RIGHT); chk("r1", 32'(dir_bin), 1);
        press(B_RIGHT); chk("r2", 32'(dir_bin), 2);
        press(B_RIGHT); chk("r3", 32'(dir_bin), 0);
        press(B_LEFT);  chk("l1", 32'(dir_bin), 2);
        press(B_LEFT | B_RIGHT); chk("lr", 32'(dir_bin), 2);
        press(B_UP);    chk("hora_inc", 32'(inc_pulse), 1);
        step(1);        chk("hora_inc_end", 32'(inc_pulse), 0);

        // commit hora -> fecha
        press(B_MODE);  chk("c0_req", 32'(wr_req), 1); chk("c0_grp", 32'(wr_grp), 0);
        chk("c0_en", 32'({en_cont_timer, en_cont_fecha, en_cont_hora}), 0);
        step(2);
        press(B_ACK);   chk("c0_done", 32'(wr_req), 0);
        chk("fecha_en", 32'(en_cont_fecha), 1); chk("fecha_dir", 32'(dir_bin), 0);

        // fecha: pulse rules
        press(B_UP | B_DOWN); chk("ud_inc", 32'(inc_pulse), 0); chk("ud_dec", 32'(dec_pulse), 0);
        press(B_UP);    chk("fe_inc", 32'(inc_pulse), 1);
        step(1);        chk("fe_inc_end", 32'(inc_pulse), 0);
        press(B_RIGHT | B_DOWN); chk("mv_dir", 32'(dir_bin), 1); chk("mv_dec", 32'(dec_pulse), 0);
        press(B_DOWN);  chk("fe_dec", 32'(dec_pulse), 1);

        // commit fecha -> timer, stray ack in edit
        press(B_MODE);  chk("c1_grp", 32'(wr_grp), 1);
        press(B_ACK);   chk("timer_en", 32'(en_cont_timer), 1); chk("timer_dir", 32'(dir_bin), 0);
        press(B_ACK);   chk("stray_ack", 32'(wr_req), 0); chk("stray_en", 32'(en_cont_timer), 1);

        // commit timer -> idle
        press(B_MODE);  chk("c2_req", 32'(wr_req), 1); chk("c2_grp", 32'(wr_grp), 2);
        press(B_UP);    chk("c2_inc", 32'(inc_pulse), 0); chk("c2_hold", 32'(wr_req), 1);
        step(5);
        press(B_ACK);   chk("c2_done", 32'(wr_req), 0); chk("c2_idle", 32'(edit_active), 0);
        chk("c2_dir", 32'(dir_bin), 0);

        // reset in the middle of a commit
        press(B_MODE); press(B_MODE); chk("pre_rst_req", 32'(wr_req), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_req", 32'(wr_req), 0);
        chk("arst_en", 32'({en_cont_timer, en_cont_fecha, en_cont_hora}), 0);
        chk("arst_active", 32'(edit_active), 0);
        @(negedge clk) reset_n = 1'b1;
        press(B_MODE);  chk("post_rst_hora", 32'(en_cont_hora), 1); chk("post_rst_dir", 32'(dir_bin), 0);

        // inactivity: abort 16 cycles after entry only with the timeout built in
        hit = 0;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk); #1;
            if (abort && hit == 0) hit = k;
        end
        chk("to_abort_at", 32'(hit), TO_EN ? 32'd16 : 32'd0);
        chk("to_active", 32'(edit_active), TO_EN ? 32'd0 : 32'd1);
        chk("to_no_req", 32'(wr_req), 0);

        // press in the terminal cycle beats the timeout
        do_reset();
        press(B_MODE);
        step(14);
        @(posedge clk); #1 drive(B_UP);
        @(posedge clk); #1 drive(6'd0);
        chk("term_inc", 32'(inc_pulse), 1); chk("term_abort", 32'(abort), 0);
        hit = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (abort) hit = 1;
        end
        chk("term_quiet", 32'(hit), 0);
        chk("term_active", 32'(edit_active), 1);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rtc_edit_ctrl.md
Name: rtc_edit_ctrl

Overview:
Sequences user editing of the RTC time, date and timer fields from debounced push-button pulses. It drives the 2-bit field address and the three group enables into the field-address decoder, and emits increment/decrement pulses to the field counters. When the user leaves a group, it runs a write-request/acknowledge handshake so the RTC bus writer commits the edited group. Sits between the button conditioning logic and the decoder/counter datapath.

Parameters:
TIMEOUT_CYCLES, 32'd500_000_000, inactivity limit in clk cycles (5 s at 100 MHz); used only with EDIT_TIMEOUT_EN.
TO_W, 32, width of the inactivity counter.

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
btn_mode  input  1  1-cycle pulse: enter edit / advance to next group
btn_left  input  1  1-cycle pulse: previous field
btn_right  input  1  1-cycle pulse: next field
btn_up  input  1  1-cycle pulse: increment selected field
btn_down  input  1  1-cycle pulse: decrement selected field
wr_ack  input  1  RTC writer acknowledge, 1-cycle pulse
dir_bin  output  2  selected field address, 0..2, registered
en_cont_hora  output  1  time group enable, registered
en_cont_fecha  output  1  date group enable, registered
en_cont_timer  output  1  timer group enable, registered
inc_pulse  output  1  1-cycle increment strobe
dec_pulse  output  1  1-cycle decrement strobe
wr_req  output  1  commit request, level until ack
wr_grp  output  2  group being committed: 0 hora, 1 fecha, 2 timer
edit_active  output  1  high in EDIT or COMMIT
abort  output  1  1-cycle pulse on timeout exit

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n. Reset drives state IDLE, grp=0, dir_bin=0, and every other output to 0. The counter also clears. Reset asserted mid-edit or mid-commit drops wr_req immediately and performs no commit.
- Registered outputs: all outputs are registered. Response appears on the cycle after the input pulse, so latency is 1.
- IDLE state: all enables low. btn_mode moves to EDIT with grp=0 and dir_bin=0. Other buttons are ignored.
- EDIT state:
  - Exactly one en_cont_* is high, selected by grp (0 hora, 1 fecha, 2 timer).
  - btn_right: dir_bin goes 0->1->2->0, wrapping 2->0.
  - btn_left: dir_bin goes 2->1->0->2, wrapping 0->2.
  - btn_up: one inc_pulse. btn_down: one dec_pulse.
  - btn_mode: go to COMMIT. wr_req=1, wr_grp=grp, all en_cont_* low.
- EDIT priority: btn_mode > left/right > up/down. Lower-priority buttons in the same cycle are dropped.
  - left and right together: no move.
  - up and down together: no pulse.
  - A move plus up/down in the same cycle: the pulse is dropped.
- COMMIT state: wr_req and wr_grp are held stable, and all buttons are ignored. On wr_ack, wr_req falls the next cycle. Then:
  - grp<2: go to EDIT with grp+1 and dir_bin=0.
  - grp==2: go to IDLE with dir_bin=0.
- Stray wr_ack: ignored outside COMMIT.
- Enables: inc_pulse and dec_pulse are never high outside EDIT. At most one en_cont_* is ever high.
- grp encoding: grp=3 is unreachable. Treat it as IDLE (recover on next clock).

Optional Feature:
EDIT_TIMEOUT_EN
- With macro:
  - A TO_W-bit counter clears on any button pulse and on entry to EDIT. It counts while in EDIT and holds in COMMIT and IDLE.
  - When the counter reaches TIMEOUT_CYCLES-1 in EDIT: go to IDLE without commit, pulse abort for 1 cycle, and drop the enables the following cycle.
  - A button pulse in the terminal cycle wins over the timeout: the counter clears and there is no abort.
- Without macro: no counter is synthesized, abort is tied 0, and EDIT persists indefinitely.

Test Plan:
1. reset_n low mid-COMMIT (wr_req=1) -> wr_req, enables, dir_bin all 0 asynchronously; after release, state is IDLE and btn_mode gives en_cont_hora=1, dir_bin=0.
2. In EDIT hora: btn_right x3 then btn_left x1 -> dir_bin 1,2,0,2.
3. In EDIT fecha: btn_up and btn_down in the same cycle -> no pulse; btn_up alone -> inc_pulse high exactly 1 cycle, next cycle after input.
4. btn_mode in EDIT timer (grp=2) -> wr_req=1, wr_grp=2, enables 0; btn_up during COMMIT -> no pulse; wr_ack after 5 cycles -> IDLE, edit_active=0.
5. btn_mode, then btn_mode, then wr_ack -> wr_grp=0 committed; EDIT fecha, en_cont_fecha=1, dir_bin=0.
6. EDIT_TIMEOUT_EN with TIMEOUT_CYCLES=16: no buttons in EDIT -> abort pulse after 16 cycles, wr_req never asserted; button pulse at cycle 15 -> no abort.
